mult_seq: RTL

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mult_seq.sv
// Sequential signed shift-add multiplier with saturated Q1.7 result.
// Latency: done/w pulse in the 9th cycle after the start cycle (WIDTH+1), issue interval WIDTH+2.
// Backpressure: none; busy stalls the issuer and start is ignored outside IDLE.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, a, b       request plus signed operands, sampled only in IDLE
//   busy              high while an operation is in RUN or DONE
//   done, w           one-cycle pulse; product/result valid, register file write enable
//   product, result   full signed product and saturated Q1.7 result, held between ops
module mult_seq #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic                 w,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   sat_next;
  logic               last;

  // One multiplier bit per RUN cycle, LSB first. The MSB of a two's-complement
  // multiplier carries negative weight, so its partial product is subtracted.
  always_comb begin
    last     = (cnt == LAST_BIT);
    addend   = {{WIDTH{a_reg[WIDTH-1]}}, a_reg} << cnt;
    acc_next = acc;
    if (b_reg[cnt]) begin
      if (last) acc_next = acc - addend;
      else      acc_next = acc + addend;
    end
  end

  // The Q1.7 window drops the top product bit; when the two top bits differ
  // that bit carried magnitude and the window would wrap, so clamp instead.
  always_comb begin
    sat_next = acc_next[FRAC+WIDTH-1:FRAC];
    if (acc_next[2*WIDTH-1] != acc_next[2*WIDTH-2]) begin
      if (acc_next[2*WIDTH-1]) sat_next = {1'b1, {(WIDTH-1){1'b0}}};
      else                     sat_next = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // busy/done/w are assigned alongside the state transition, so each is a
  // registered decode of state and start has no combinational path to busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      w       <= 1'b0;
      product <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (last) begin
            product <= acc_next;
            result  <= sat_next;
            done    <= 1'b1;
            w       <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          w     <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          w     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
